// File: rtl/servo_pkg.sv
// Shared widths, default timing and calc FSM encoding for the servo PWM controller.
// Slew limiting is enabled by defining SERVO_SLEW_EN.
package servo_pkg;

    localparam int COUNT_W = 24;
    localparam int ANGLE_W = 8;

    localparam int DEF_PERIOD_CYCLES = 1000000;
    localparam int DEF_MIN_PULSE     = 50000;
    localparam int DEF_MAX_PULSE     = 100000;
    localparam int DEF_CYC_PER_DEG   = 278;
    localparam int DEF_ANGLE_MAX     = 180;
    localparam int DEF_RESET_ANGLE   = 90;
    localparam int DEF_SLEW_DEG      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        CLAMP = 2'd2,
        DONE  = 2'd3
    } calc_state_t;

    function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [15:0]        angle,
                                                       input logic [ANGLE_W-1:0] angle_max);
        return (angle > {8'd0, angle_max}) ? angle_max : angle[ANGLE_W-1:0];
    endfunction

endpackage

// File: rtl/servo_pulse_calc.sv
// Angle to pulse-width converter: 8-cycle shift-add multiply, offset and saturate.
//   state | meaning
//   IDLE  | no result yet since reset, waiting for start
//   MUL   | one multiplier bit per cycle into the accumulator
//   CLAMP | add MIN_PULSE, saturate at MAX_PULSE, latch result
//   DONE  | result valid and held until the next start
module servo_pulse_calc
    import servo_pkg::*;
#(
    parameter int MIN_PULSE   = DEF_MIN_PULSE,
    parameter int MAX_PULSE   = DEF_MAX_PULSE,
    parameter int CYC_PER_DEG = DEF_CYC_PER_DEG
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ANGLE_W-1:0] operand,
    output logic               done,
    output logic [COUNT_W-1:0] result
);

    calc_state_t          state, next_state;
    logic [2:0]           bit_cnt;
    logic [COUNT_W-1:0]   mcand;
    logic [ANGLE_W-1:0]   mplier;
    logic [COUNT_W-1:0]   acc;
    logic [COUNT_W:0]     sum;
    logic [COUNT_W-1:0]   sat;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = MUL;
            MUL:     if (bit_cnt == 3'd7) next_state = CLAMP;
            CLAMP:   next_state = DONE;
            DONE:    if (start) next_state = MUL;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sum = {1'b0, acc} + (COUNT_W+1)'(MIN_PULSE);
        sat = (sum > (COUNT_W+1)'(MAX_PULSE)) ? COUNT_W'(MAX_PULSE) : sum[COUNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        mcand   <= COUNT_W'(CYC_PER_DEG);
                        mplier  <= operand;
                        acc     <= '0;
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                CLAMP:   result <= sat;
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Frame-synchronous servo PWM: frame counter, clamped target, tracked angle, pulse output.
// Define SERVO_SLEW_EN to limit angle_cur movement to SLEW_DEG per frame.
module servo_pwm_ctrl
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int MIN_PULSE     = DEF_MIN_PULSE,
    parameter int MAX_PULSE     = DEF_MAX_PULSE,
    parameter int CYC_PER_DEG   = DEF_CYC_PER_DEG,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int RESET_ANGLE   = DEF_RESET_ANGLE,
    parameter int SLEW_DEG      = DEF_SLEW_DEG
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        angle_in,
    input  logic               enable,
    output logic               servo_out,
    output logic               frame_start,
    output logic [ANGLE_W-1:0] angle_cur,
    output logic               at_target
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(PERIOD_CYCLES - 1);

    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] pulse_width;
    logic [ANGLE_W-1:0] target;
    logic [ANGLE_W-1:0] next_angle;
    logic               en_q;
    logic               boundary;
    logic               calc_done;
    logic [COUNT_W-1:0] calc_result;

    assign boundary = (count == LAST_COUNT);

`ifdef SERVO_SLEW_EN
    localparam logic [ANGLE_W-1:0] SLEW = ANGLE_W'(SLEW_DEG);

    always_comb begin
        next_angle = target;
        if (target > angle_cur) begin
            if (target - angle_cur > SLEW) next_angle = angle_cur + SLEW;
        end else if (angle_cur - target > SLEW) begin
            next_angle = angle_cur - SLEW;
        end
    end
`else
    assign next_angle = target;
`endif

    servo_pulse_calc #(
        .MIN_PULSE  (MIN_PULSE),
        .MAX_PULSE  (MAX_PULSE),
        .CYC_PER_DEG(CYC_PER_DEG)
    ) u_calc (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (frame_start),
        .operand(angle_cur),
        .done   (calc_done),
        .result (calc_result)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count       <= '0;
            frame_start <= 1'b0;
            angle_cur   <= ANGLE_W'(RESET_ANGLE);
            target      <= ANGLE_W'(RESET_ANGLE);
            pulse_width <= '0;
            en_q        <= 1'b0;
            servo_out   <= 1'b0;
            at_target   <= 1'b1;
        end else begin
            count       <= boundary ? '0 : count + COUNT_W'(1);
            frame_start <= boundary;
            servo_out   <= en_q && (count < pulse_width);
            // Everything below changes only at the frame edge so pulses are never cut short.
            if (boundary) begin
                target      <= clamp_angle(angle_in, ANGLE_W'(ANGLE_MAX));
                en_q        <= enable;
                pulse_width <= calc_done ? calc_result : '0;
                angle_cur   <= next_angle;
            end
`ifdef SERVO_SLEW_EN
            at_target <= (angle_cur == target);
`else
            at_target <= 1'b1;
`endif
        end
    end

endmodule
